// File: rtl/move_sched_pkg.sv
// Shared command encoding, FSM state type and gravity period helper for move_scheduler.
package move_sched_pkg;

   localparam logic [2:0] CMD_NONE    = 3'd0;
   localparam logic [2:0] CMD_LEFT    = 3'd1;
   localparam logic [2:0] CMD_RIGHT   = 3'd2;
   localparam logic [2:0] CMD_SOFT    = 3'd3;
   localparam logic [2:0] CMD_ROTATE  = 3'd4;
   localparam logic [2:0] CMD_GRAVITY = 3'd5;
   localparam logic [2:0] CMD_LOCK    = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HALT
   } state_t;

   // max(base - lvl*step, floor_p), computed wide so large levels cannot wrap
   function automatic logic [23:0] grav_period(input logic [23:0] base,
                                               input logic [23:0] step,
                                               input logic [23:0] floor_p,
                                               input logic [3:0]  lvl);
      logic [27:0] dec;
      logic [27:0] span;
      dec  = {24'd0, lvl} * {4'd0, step};
      span = {4'd0, base};
      if ((span > dec) && ((span - dec) > {4'd0, floor_p}))
         return base - dec[23:0];
      return floor_p;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// One button: 2-flop synchronizer, rising-edge detect and optional DAS/ARR auto-repeat.
// req is a one-cycle pulse; held is the synchronized button level.
module key_repeat #(
   parameter bit          REPEAT_EN  = 1'b1,
   parameter logic [23:0] DAS_CYCLES = 24'd8_000_000,
   parameter logic [23:0] ARR_CYCLES = 24'd2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic held,
   output logic req
);

   logic        sync1;
   logic        sync2;
   logic        prev;
   logic        rep;
   logic [23:0] cnt;
   logic        rise;
   logic        hit;
   logic [23:0] target;

   // Edge and repeat-hit decode; cnt counts cycles held since the last request
   always_comb begin
      rise   = sync2 & ~prev;
      target = rep ? ARR_CYCLES : DAS_CYCLES;
      hit    = (REPEAT_EN != 1'b0) && sync2 && !rise && (cnt == target);
      held   = sync2;
      req    = rise | hit;
   end

   // Synchronizer, edge register and DAS/ARR hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         rep   <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         prev  <= sync2;
         if (!sync2) begin
            cnt <= '0;
            rep <= 1'b0;
         end else if (rise) begin
            cnt <= 24'd1;
            rep <= 1'b0;
         end else if (hit) begin
            cnt <= 24'd1;
            rep <= 1'b1;
         end else begin
            cnt <= cnt + 24'd1;
         end
      end
   end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates button requests and gravity ticks into a single command stream
// to the board logic, with LOCK escalation and a terminal game-over state.
module move_scheduler
   import move_sched_pkg::*;
#(
   parameter logic [23:0] GRAV_BASE  = 24'd12_500_000,
   parameter logic [23:0] GRAV_STEP  = 24'd1_000_000,
   parameter logic [23:0] GRAV_MIN   = 24'd1_000_000,
   parameter logic [23:0] DAS_CYCLES = 24'd8_000_000,
   parameter logic [23:0] ARR_CYCLES = 24'd2_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       run,
   input  logic [3:0] level,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   input  logic       cmd_ready,
   input  logic       resp_valid,
   input  logic       resp_blocked,
   output logic       busy,
   output logic       game_over
);

   state_t      state;
   state_t      state_next;
   logic [2:0]  cmd_reg;
   logic [2:0]  cmd_next;
   logic        game_over_next;

   logic        req_rot, req_left, req_right, req_soft;
   logic        held_left, held_right;
   logic        held_rot_unused, held_soft_unused;

   logic        pend_rot, pend_left, pend_right, pend_soft, pend_grav;
   logic [23:0] grav_cnt;
   logic [23:0] grav_per;
   logic        grav_run;
   logic        grav_tick;

   logic        acc;
   logic        lock_acc;
   logic        both_held;
   logic [2:0]  winner;
   logic        any_pend;

   key_repeat #(.REPEAT_EN(1'b0), .DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_rot (
      .clk(clk), .rst_n(rst_n), .button(up), .held(held_rot_unused), .req(req_rot));
   key_repeat #(.REPEAT_EN(1'b1), .DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_left (
      .clk(clk), .rst_n(rst_n), .button(left), .held(held_left), .req(req_left));
   key_repeat #(.REPEAT_EN(1'b1), .DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_right (
      .clk(clk), .rst_n(rst_n), .button(right), .held(held_right), .req(req_right));
   key_repeat #(.REPEAT_EN(1'b1), .DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_soft (
      .clk(clk), .rst_n(rst_n), .button(down), .held(held_soft_unused), .req(req_soft));

   // Handshake, gravity tick and fixed-priority winner selection
   always_comb begin
      acc       = (state == ISSUE) && cmd_ready;
      lock_acc  = acc && (cmd_reg == CMD_LOCK);
      both_held = held_left & held_right;
      grav_run  = run & ~game_over;
      grav_tick = grav_run && (grav_cnt >= (grav_per - 24'd1));
      any_pend  = pend_rot | pend_left | pend_right | pend_soft | pend_grav;
      winner    = CMD_NONE;
      if (pend_rot)        winner = CMD_ROTATE;
      else if (pend_left)  winner = CMD_LEFT;
      else if (pend_right) winner = CMD_RIGHT;
      else if (pend_soft)  winner = CMD_SOFT;
      else if (pend_grav)  winner = CMD_GRAVITY;
   end

   // Button pending flags: a fresh request outranks clearing by its own accept,
   // but LOCK and a left+right conflict clear unconditionally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_rot   <= 1'b0;
         pend_left  <= 1'b0;
         pend_right <= 1'b0;
         pend_soft  <= 1'b0;
      end else begin
         if (lock_acc)                           pend_rot <= 1'b0;
         else if (req_rot)                       pend_rot <= 1'b1;
         else if (acc && cmd_reg == CMD_ROTATE)  pend_rot <= 1'b0;

         if (lock_acc || both_held)              pend_left <= 1'b0;
         else if (req_left)                      pend_left <= 1'b1;
         else if (acc && cmd_reg == CMD_LEFT)    pend_left <= 1'b0;

         if (lock_acc || both_held)              pend_right <= 1'b0;
         else if (req_right)                     pend_right <= 1'b1;
         else if (acc && cmd_reg == CMD_RIGHT)   pend_right <= 1'b0;

         if (lock_acc)                           pend_soft <= 1'b0;
         else if (req_soft)                      pend_soft <= 1'b1;
         else if (acc && cmd_reg == CMD_SOFT)    pend_soft <= 1'b0;
      end
   end

   // Gravity counter; accepted SOFT or LOCK restarts the period and drops the tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grav_cnt  <= '0;
         grav_per  <= GRAV_BASE;
         pend_grav <= 1'b0;
      end else if (acc && (cmd_reg == CMD_SOFT || cmd_reg == CMD_LOCK)) begin
         grav_cnt  <= '0;
         grav_per  <= grav_period(GRAV_BASE, GRAV_STEP, GRAV_MIN, level);
         pend_grav <= 1'b0;
      end else if (grav_tick) begin
         grav_cnt  <= '0;
         grav_per  <= grav_period(GRAV_BASE, GRAV_STEP, GRAV_MIN, level);
         pend_grav <= 1'b1;
      end else begin
         if (grav_run)
            grav_cnt <= grav_cnt + 24'd1;
         if (acc && cmd_reg == CMD_GRAVITY)
            pend_grav <= 1'b0;
      end
   end

   // FSM state, latched command and sticky game-over
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_reg   <= CMD_NONE;
         game_over <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_reg   <= cmd_next;
         game_over <= game_over_next;
      end
   end

   // FSM next state and command outputs
   always_comb begin
      state_next     = state;
      cmd_next       = cmd_reg;
      game_over_next = game_over;
      cmd_valid      = 1'b0;
      busy           = 1'b0;
      cmd            = CMD_NONE;
      case (state)
         IDLE: begin
            if (run && any_pend) begin
               state_next = ISSUE;
               cmd_next   = winner;
            end
         end
         ISSUE: begin
            cmd_valid = 1'b1;
            busy      = 1'b1;
            cmd       = cmd_reg;
            if (cmd_ready)
               state_next = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            cmd  = cmd_reg;
            if (resp_valid) begin
               if (resp_blocked && (cmd_reg == CMD_SOFT || cmd_reg == CMD_GRAVITY)) begin
                  state_next = ISSUE;
                  cmd_next   = CMD_LOCK;
               end else if (resp_blocked && cmd_reg == CMD_LOCK) begin
                  state_next     = HALT;
                  game_over_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         HALT: begin
            state_next = HALT;
         end
      endcase
   end

endmodule
